// File: rtl/run_checker_pkg.sv
// run_checker_pkg: shared types for the run-and-check sequencer.
//   state_t : sequencer phases. IDLE and DONE park the processor in reset,
//             RESET holds it there before release, RUN lets it execute, and
//             CHECK scans the register file against the expected-value ROM.
package run_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/run_checker_cmp.sv
// run_checker_cmp: register-versus-expected comparator for the CHECK scan.
//   clk, reset    : clock, asynchronous active-low reset
//   clear         : wipe all results (a new run has been accepted)
//   valid         : idx/got/exp carry a register under test this cycle
//   idx           : register index being compared
//   got, exp      : register-file data and expected data for idx
//   err_count     : number of mismatching registers, saturating at NREGS-1
//   fail_idx/got/exp : details of the first mismatch since clear
//   any_err       : a mismatch is already counted or is being seen right now,
//                   so the top can register pass on the same edge that the
//                   final compare lands in err_count
module run_checker_cmp #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       valid,
  input  logic [$clog2(NREGS)-1:0]   idx,
  input  logic [DATA_W-1:0]          got,
  input  logic [DATA_W-1:0]          exp,
  output logic [$clog2(NREGS)-1:0]   err_count,
  output logic [$clog2(NREGS)-1:0]   fail_idx,
  output logic [DATA_W-1:0]          fail_got,
  output logic [DATA_W-1:0]          fail_exp,
  output logic                       any_err
);

  localparam int IDX_W = $clog2(NREGS);

  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] c);
    if (c == IDX_W'(NREGS - 1)) return c;
    return c + IDX_W'(1);
  endfunction

  logic mism;

  always_comb begin
    mism    = valid && (got != exp);
    any_err = (err_count != '0) || mism;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
      fail_idx  <= '0;
      fail_got  <= '0;
      fail_exp  <= '0;
    end else if (clear) begin
      err_count <= '0;
      fail_idx  <= '0;
      fail_got  <= '0;
      fail_exp  <= '0;
    end else if (mism) begin
      err_count <= sat_inc(err_count);
      // Only the first mismatch of a run is kept for diagnosis.
      if (err_count == '0) begin
        fail_idx <= idx;
        fail_got <= got;
        fail_exp <= exp;
      end
    end
  end

endmodule

// File: rtl/run_checker.sv
// run_checker: hardware run-and-check sequencer for the MIPS processor.
// Parks the processor in reset, releases it for a programmable cycle budget
// (optionally ending early on halt), then scans the register file through a
// read port and compares each entry with an expected-value ROM.
//   clk, reset     : clock, asynchronous active-low reset
//   start          : begin a run (only honoured in IDLE/DONE)
//   run_cycles     : cycle budget, captured when start is accepted
//   cpu_halt       : processor halt flag (used only when HALT_MODE != 0)
//   cpu_reset      : active-high reset to the processor
//   reg_raddr/reg_rdata : register-file read port (combinational read)
//   exp_raddr/exp_rdata : expected-value ROM read port (same address)
//   busy, done     : sequencer activity / completion level
//   pass, timeout  : result flags, meaningful while done
//   err_count, fail_idx, fail_got, fail_exp : mismatch count, first mismatch
//   cycles_used    : RUN cycles actually executed
module run_checker #(
  parameter int DATA_W     = 32,
  parameter int NREGS      = 32,
  parameter int CYC_W      = 16,
  parameter int RST_CYCLES = 2,
  parameter int HALT_MODE  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [CYC_W-1:0]           run_cycles,
  input  logic                       cpu_halt,
  output logic                       cpu_reset,
  output logic [$clog2(NREGS)-1:0]   reg_raddr,
  input  logic [DATA_W-1:0]          reg_rdata,
  output logic [$clog2(NREGS)-1:0]   exp_raddr,
  input  logic [DATA_W-1:0]          exp_rdata,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       timeout,
  output logic [$clog2(NREGS)-1:0]   err_count,
  output logic [$clog2(NREGS)-1:0]   fail_idx,
  output logic [DATA_W-1:0]          fail_got,
  output logic [DATA_W-1:0]          fail_exp,
  output logic [CYC_W-1:0]           cycles_used
);

  import run_checker_pkg::*;

  localparam int IDX_W = $clog2(NREGS);
  localparam int RST_W = $clog2(RST_CYCLES + 1);

  state_t           state, state_nx;
  logic [RST_W-1:0] rst_cnt;
  logic [CYC_W-1:0] budget;
  logic             accept;
  logic             halt_hit;
  logic             budget_hit;
  logic             timeout_set;
  logic             chk_last;
  logic             any_err;

  always_comb begin
    accept      = start && ((state == ST_IDLE) || (state == ST_DONE));
    halt_hit    = (HALT_MODE != 0) && cpu_halt;
    // Current RUN cycle is the last one the budget allows.
    budget_hit  = (cycles_used == budget - CYC_W'(1));
    timeout_set = (state == ST_RUN) && (HALT_MODE != 0) && !cpu_halt && budget_hit;
    chk_last    = (reg_raddr == IDX_W'(NREGS - 1));

    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_RESET;
      // RESET covers the capture cycle plus RST_CYCLES hold cycles.
      ST_RESET: if (rst_cnt == RST_W'(RST_CYCLES))
                  state_nx = (budget == '0) ? ST_CHECK : ST_RUN;
      ST_RUN: begin
        if (halt_hit)        state_nx = ST_CHECK;
        else if (budget_hit) state_nx = (HALT_MODE != 0) ? ST_DONE : ST_CHECK;
      end
      ST_CHECK: if (chk_last) state_nx = ST_DONE;
      ST_DONE:  if (accept) state_nx = ST_RESET;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Captured budget is only consulted after an accepted start.
  always_ff @(posedge clk) begin
    if (accept) budget <= run_cycles;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_cnt     <= '0;
      cycles_used <= '0;
      reg_raddr   <= '0;
      cpu_reset   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      rst_cnt <= (state == ST_RESET) ? rst_cnt + RST_W'(1) : '0;

      if (accept)                cycles_used <= '0;
      else if (state == ST_RUN)  cycles_used <= cycles_used + CYC_W'(1);

      // Address comes from a register so the combinational read data is
      // compared in the same cycle it is presented.
      if (state_nx == ST_CHECK)
        reg_raddr <= (state == ST_CHECK) ? reg_raddr + IDX_W'(1) : IDX_W'(1);
      else
        reg_raddr <= '0;

      cpu_reset <= (state_nx != ST_RUN);
      busy      <= (state_nx == ST_RESET) || (state_nx == ST_RUN) || (state_nx == ST_CHECK);
      done      <= (state_nx == ST_DONE);

      if (accept) begin
        pass    <= 1'b0;
        timeout <= 1'b0;
      end else if ((state != ST_DONE) && (state_nx == ST_DONE)) begin
        pass    <= !timeout_set && !any_err;
        timeout <= timeout_set;
      end
    end
  end

  assign exp_raddr = reg_raddr;

  run_checker_cmp #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_cmp (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .valid     (state == ST_CHECK),
    .idx       (reg_raddr),
    .got       (reg_rdata),
    .exp       (exp_rdata),
    .err_count (err_count),
    .fail_idx  (fail_idx),
    .fail_got  (fail_got),
    .fail_exp  (fail_exp),
    .any_err   (any_err)
  );

endmodule

// File: tb/tb_run_checker.sv
// Bench for run_checker: two instances (HALT_MODE 0 and 1) share a register
// file and an expected ROM. A timeline model derived from the start edge,
// budget and halt plan predicts every output each cycle.
module tb_run_checker;

  localparam int DW    = 32;
  localparam int NR    = 32;
  localparam int CW    = 16;
  localparam int RSTC  = 2;
  localparam int IW    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [CW-1:0] run_cycles;
  logic          start    [2];
  logic          cpu_halt [2];
  logic          cpu_reset[2];
  logic          busy     [2];
  logic          done     [2];
  logic          pass     [2];
  logic          timeout  [2];
  logic [IW-1:0] reg_raddr[2];
  logic [IW-1:0] exp_raddr[2];
  logic [IW-1:0] err_count[2];
  logic [IW-1:0] fail_idx [2];
  logic [DW-1:0] reg_rdata[2];
  logic [DW-1:0] exp_rdata[2];
  logic [DW-1:0] fail_got [2];
  logic [DW-1:0] fail_exp [2];
  logic [CW-1:0] cycles_used[2];

  logic [DW-1:0] regs [NR];
  logic [DW-1:0] rom  [NR];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    run_checker #(
      .DATA_W(DW), .NREGS(NR), .CYC_W(CW), .RST_CYCLES(RSTC), .HALT_MODE(g)
    ) u_dut (
      .clk(clk), .reset(reset), .start(start[g]), .run_cycles(run_cycles),
      .cpu_halt(cpu_halt[g]), .cpu_reset(cpu_reset[g]),
      .reg_raddr(reg_raddr[g]), .reg_rdata(reg_rdata[g]),
      .exp_raddr(exp_raddr[g]), .exp_rdata(exp_rdata[g]),
      .busy(busy[g]), .done(done[g]), .pass(pass[g]), .timeout(timeout[g]),
      .err_count(err_count[g]), .fail_idx(fail_idx[g]),
      .fail_got(fail_got[g]), .fail_exp(fail_exp[g]),
      .cycles_used(cycles_used[g])
    );
    assign reg_rdata[g] = regs[reg_raddr[g]];
    assign exp_rdata[g] = rom[exp_raddr[g]];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d] t=%0t got=%0h expected=%0h", nm, i, $time, got, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  int  cyc = 0;
  int  halt_plan[2];
  int  m_act [2];
  int  m_t0  [2];
  int  m_n   [2];
  int  m_tout[2];
  int  m_d   [2];
  logic [DW-1:0] s_got[2][NR];
  logic [DW-1:0] s_exp[2][NR];

  function automatic int plan_n(int bud, int h, int hm);
    if (hm != 0 && h >= 1 && h <= bud) return h;
    return bud;
  endfunction

  function automatic int plan_tout(int bud, int h, int hm);
    return (hm != 0 && bud > 0 && !(h >= 1 && h <= bud)) ? 1 : 0;
  endfunction

  function automatic int plan_d(int bud, int h, int hm);
    if (plan_tout(bud, h, hm) != 0) return RSTC + plan_n(bud, h, hm) + 1;
    return RSTC + plan_n(bud, h, hm) + NR;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) m_act[i] <= 0;
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (start[i] && (m_act[i] == 0 || (cyc - m_t0[i]) >= m_d[i])) begin
          m_act[i]  <= 1;
          m_t0[i]   <= cyc + 1;
          m_n[i]    <= plan_n(int'(run_cycles), halt_plan[i], i);
          m_tout[i] <= plan_tout(int'(run_cycles), halt_plan[i], i);
          m_d[i]    <= plan_d(int'(run_cycles), halt_plan[i], i);
          for (int k = 0; k < NR; k++) begin
            s_got[i][k] <= regs[k];
            s_exp[i][k] <= rom[k];
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int d, n, a_lim, e_err, e_fidx, e_cyc, e_addr;
  logic e_busy, e_done, e_cr, e_pass, e_to;
  logic [DW-1:0] e_fg, e_fe;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      e_busy = 0; e_done = 0; e_cr = 1; e_pass = 0; e_to = 0;
      e_err = 0; e_fidx = 0; e_cyc = 0; e_addr = 0; e_fg = '0; e_fe = '0;
      if (m_act[i] != 0) begin
        d = cyc - m_t0[i];
        n = m_n[i];
        e_busy = (d < m_d[i]);
        e_done = !e_busy;
        e_cr   = !(d >= RSTC + 1 && d <= RSTC + n);
        e_cyc  = d - RSTC - 1;
        if (e_cyc < 0) e_cyc = 0;
        if (e_cyc > n) e_cyc = n;
        if (m_tout[i] == 0 && d > RSTC + n && d < m_d[i]) e_addr = d - RSTC - n;
        if (m_tout[i] != 0 || d <= RSTC + n) a_lim = 0;
        else if (d < m_d[i])                 a_lim = d - RSTC - n - 1;
        else                                 a_lim = NR - 1;
        for (int k = 1; k <= a_lim; k++) begin
          if (s_got[i][k] != s_exp[i][k]) begin
            if (e_err == 0) begin
              e_fidx = k; e_fg = s_got[i][k]; e_fe = s_exp[i][k];
            end
            e_err++;
          end
        end
        if (e_err > NR - 1) e_err = NR - 1;
        e_pass = e_done && m_tout[i] == 0 && e_err == 0;
        e_to   = e_done && m_tout[i] != 0;
      end
      chk("cpu_reset",   i, cpu_reset[i],   e_cr);
      chk("busy",        i, busy[i],        e_busy);
      chk("done",        i, done[i],        e_done);
      chk("pass",        i, pass[i],        e_pass);
      chk("timeout",     i, timeout[i],     e_to);
      chk("reg_raddr",   i, reg_raddr[i],   e_addr);
      chk("exp_raddr",   i, exp_raddr[i],   e_addr);
      chk("cycles_used", i, cycles_used[i], e_cyc);
      chk("err_count",   i, err_count[i],   e_err);
      chk("fail_idx",    i, fail_idx[i],    e_fidx);
      chk("fail_got",    i, fail_got[i],    e_fg);
      chk("fail_exp",    i, fail_exp[i],    e_fe);
    end
  end

  // ---------------- stimulus ----------------
  // Pulse start, optionally pulse it again later (pulse>0) and raise the
  // halt flag in RUN cycle h; returns edges from the accepting edge to done.
  task automatic do_run(input int i, input int bud, input int h, input int pulse, output int lat);
    int cnt;
    @(negedge clk);
    halt_plan[i] = h;
    run_cycles   = CW'(bud);
    start[i]     = 1'b1;
    @(posedge clk);
    cnt = 0;
    @(negedge clk);
    start[i] = 1'b0;
    while (!done[i] && cnt < 400) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      start[i]    = (pulse > 0 && cnt == pulse);
      cpu_halt[i] = (h > 0 && cnt == RSTC + h);
    end
    start[i]    = 1'b0;
    cpu_halt[i] = 1'b0;
    chk("done_wait", i, done[i], 1);
    lat = cnt;
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    run_cycles = '0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; cpu_halt[i] = 1'b0; halt_plan[i] = 0;
    end
    regs[0] = 32'd0;
    regs[1] = 32'd1;
    for (int k = 2; k < NR; k++) regs[k] = regs[k-1] + regs[k-2];
    for (int k = 0; k < NR; k++) rom[k] = regs[k];
    rom[0] = 32'hFFFF_FFFF;  // entry 0 must never be compared
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_reset", 0, cpu_reset[0], 1);
    chk("rst_busy",      1, busy[1],      0);
    #2 reset = 1'b1;
    @(negedge clk);

    // Full budget, correct ROM; halt pulse ignored with HALT_MODE=0.
    do_run(0, 29, 5, 0, lat);
    chk("lat_budget29", 0, lat, 63);
    chk("pass_ok", 0, pass[0], 1);
    chk("err_ok", 0, err_count[0], 0);
    chk("cyc_29", 0, cycles_used[0], 29);

    // Corrupted ROM; restart straight from DONE.
    rom[5] = 32'hDEAD_BEEF;
    rom[9] = 32'd0;
    do_run(0, 20, 0, 0, lat);
    chk("lat_budget20", 0, lat, 54);
    chk("pass_bad", 0, pass[0], 0);
    chk("err_two", 0, err_count[0], 2);
    chk("fail_idx5", 0, fail_idx[0], 5);
    chk("fail_exp5", 0, fail_exp[0], 32'hDEAD_BEEF);
    chk("fail_got5", 0, fail_got[0], 5);
    rom[5] = regs[5];
    rom[9] = regs[9];

    // Halt in RUN cycle 7 of a 100-cycle budget.
    do_run(1, 100, 7, 0, lat);
    chk("lat_halt7", 1, lat, 41);
    chk("cyc_halt7", 1, cycles_used[1], 7);
    chk("to_halt7", 1, timeout[1], 0);
    chk("pass_halt7", 1, pass[1], 1);

    // No halt: budget expires, CHECK skipped.
    do_run(1, 10, 0, 0, lat);
    chk("lat_tout", 1, lat, 13);
    chk("to_set", 1, timeout[1], 1);
    chk("pass_tout", 1, pass[1], 0);
    chk("err_tout", 1, err_count[1], 0);

    // Zero budget, with a start pulse during CHECK.
    do_run(0, 0, 0, RSTC + 10, lat);
    chk("lat_zero", 0, lat, 34);
    chk("cyc_zero", 0, cycles_used[0], 0);
    chk("pass_zero", 0, pass[0], 1);

    // Async reset in RUN cycle 3, then a clean run.
    @(negedge clk);
    halt_plan[0] = 0;
    run_cycles = CW'(20);
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (RSTC + 3) @(negedge clk);
    chk("run_before_rst", 0, cpu_reset[0], 0);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("arst_busy", 0, busy[0], 0);
    chk("arst_cpu_reset", 0, cpu_reset[0], 1);
    chk("arst_done", 0, done[0], 0);
    #2 reset = 1'b1;
    @(negedge clk);
    do_run(0, 5, 0, 0, lat);
    chk("lat_after_rst", 0, lat, 39);
    chk("pass_after_rst", 0, pass[0], 1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/run_checker.md
# run_checker

Synthesisable run-and-check controller for the MIPS processor, replacing the fixed-delay, simulation-only check sequence with a reusable hardware sequencer. It holds the processor in reset, releases it for a programmable cycle budget (or until a halt indication), then scans the register file through a read port. It compares every register against an expected-value port and reports pass/fail, mismatch count and first-mismatch detail. It sits between the processor top and an expected-value ROM, and is usable on FPGA and in simulation alike.

## Interface
- `DATA_W`, 32, register/expected data width
- `NREGS`, 32, register-file entries; entry 0 is never checked
- `CYC_W`, 16, width of cycle budget and cycle counter
- `RST_CYCLES`, 2, cycles `cpu_reset` is held high after start (≥1)
- `HALT_MODE`, 0, 1 = RUN also ends early on `cpu_halt`
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a run; sampled only in IDLE/DONE
- `run_cycles`  in  CYC_W  cycle budget; captured on accepted `start`
- `cpu_halt`  in  1  processor halt flag (ignored when HALT_MODE=0)
- `cpu_reset`  out  1  active-high reset to processor
- `reg_raddr`  out  $clog2(NREGS)  register-file read address
- `reg_rdata`  in  DATA_W  register-file data, combinational read
- `exp_raddr`  out  $clog2(NREGS)  expected-value ROM address (always equals `reg_raddr`)
- `exp_rdata`  in  DATA_W  expected data, combinational read
- `busy`  out  1  high in RESET/RUN/CHECK
- `done`  out  1  level, high in DONE until next accepted start
- `pass`  out  1  valid while `done`; 1 = no mismatch and no timeout
- `timeout`  out  1  valid while `done`; HALT_MODE budget expired
- `err_count`  out  $clog2(NREGS)  number of mismatching registers
- `fail_idx`, `fail_got`, `fail_exp`  out  idx/DATA_W/DATA_W  first mismatch
- `cycles_used`  out  CYC_W  RUN cycles actually executed

## Operation
- States: IDLE → RESET → RUN → CHECK → DONE. DONE → RESET on `start`.
- IDLE/DONE: `cpu_reset`=1, so the processor is parked in reset.
- Accepted `start`:
  - captures `run_cycles`;
  - clears `err_count`, `fail_*`, `cycles_used`, `pass`, `timeout`;
  - enters RESET.
- `start` while busy is ignored.
- RESET: `cpu_reset`=1 for exactly RST_CYCLES cycles, then RUN.
- RUN: `cpu_reset`=0; `cycles_used` increments every RUN cycle. Exits when:
  - `cycles_used` reaches the captured budget → CHECK;
  - HALT_MODE=1 and `cpu_halt` is high → CHECK at that edge, with the halt cycle counted;
  - budget is 0 → RUN is skipped and RESET goes directly to CHECK.
- HALT_MODE=1 and budget expires without halt → DONE with `timeout`=1 and `pass`=0; CHECK is skipped.
- CHECK:
  - `cpu_reset`=1, freezing the register file;
  - `reg_raddr` steps 1..NREGS-1, one per cycle;
  - on each mismatch, `err_count` increments (saturating at NREGS-1);
  - `fail_*` captures the first mismatch only.
- DONE: `pass` = (`err_count`==0) && !`timeout`.
- Async reset (active-low): returns to IDLE at any time, including mid-RUN or mid-CHECK.

## Timing
- Reset values:
  - `cpu_reset`=1;
  - `busy`, `done`, `pass`, `timeout` = 0;
  - `reg_raddr`, `err_count`, `fail_*`, `cycles_used` = 0.
- Start accepted at edge E. States then occupy:
  - RESET: cycles E+1..E+RST_CYCLES;
  - RUN: next N cycles (N = budget, or fewer on halt);
  - CHECK: next NREGS-1 cycles;
  - `done` rises at the following edge.
- Total latency start→done = RST_CYCLES + N + NREGS − 1 + 1 edges.
- All outputs are registered. `reg_raddr` is driven from state/counter registers so that combinational read data is compared in the same cycle.
- `start` held high in DONE restarts immediately. `done` drops on the edge that accepts it.

## Structure
- Package `run_checker_pkg`: state enum (IDLE, RESET, RUN, CHECK, DONE).
- Natural sub-module `run_checker_cmp`: compare, `err_count` saturation and first-fail capture, driven by `idx`/`valid`/`clear`. The FSM and counters stay in the top module.
- The processor top exposes a read port on the GPR file, replacing hierarchical peeking.

## Test plan
- Fibonacci program, budget 29, HALT_MODE=0, expected ROM correct → `done` at start+2+29+31+1 edges; `pass`=1, `err_count`=0, `cycles_used`=29.
- Expected ROM entry 5 corrupted to 0xDEADBEEF, entry 9 to 0 → `pass`=0, `err_count`=2, `fail_idx`=5, `fail_exp`=0xDEADBEEF, `fail_got`=actual r5.
- HALT_MODE=1, `cpu_halt` asserted in RUN cycle 7, budget 100 → `cycles_used`=7, CHECK follows, `timeout`=0.
- HALT_MODE=1, no halt, budget 10 → `done` after 2+10+1 edges; `timeout`=1, `pass`=0, `err_count`=0.
- Budget 0 → no RUN cycles, `cycles_used`=0, CHECK runs normally. `start` pulsed during CHECK → ignored.
- `reset` low in RUN cycle 3 → next cycle IDLE, `cpu_reset`=1, `busy`=0, `done`=0; a new `start` then completes normally.
